// File: rtl/idft_8_pkg.sv
// Shared constants and FSM state encoding for the 8-point serial IDFT.
package idft_8_pkg;

  localparam int          FRAME_LEN = 8;
  localparam logic [31:0] WQ_SRC    = 32'hB504F334;  // 0.70710678 in Q0.32

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_MAC,
    ST_HOLD
  } idft_state_e;

  // Top p bits of WQ_SRC: the twiddle magnitude with p fractional bits.
  function automatic logic [31:0] wq_top(int p);
    return WQ_SRC >> (32 - p);
  endfunction

endpackage

// File: rtl/idft_8_seq_if.sv
// Sample-in / sample-out handshake bundle of the 8-point serial IDFT.
interface idft_8_seq_if #(
  parameter int N = 32
);

  logic signed [N-1:0] in_r;
  logic signed [N-1:0] in_i;
  logic                in_valid;
  logic                in_ready;

  logic signed [N-1:0] out_r;
  logic signed [N-1:0] out_i;
  logic        [2:0]   out_idx;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_r, in_i, in_valid, out_ready,
    input  in_ready, out_r, out_i, out_idx, out_valid
  );

  modport slave (
    input  in_r, in_i, in_valid, out_ready,
    output in_ready, out_r, out_i, out_idx, out_valid
  );

endinterface

// File: rtl/idft_tw_mul.sv
// Combinational complex multiply by W8^(-idx) = exp(+j*pi*idx/4), idx 0..7.
module idft_tw_mul
  import idft_8_pkg::*;
#(
  parameter int N = 32,
  parameter int P = 10
) (
  input  logic signed [N-1:0] i_re,
  input  logic signed [N-1:0] i_im,
  input  logic        [2:0]   i_idx,
  output logic signed [N:0]   o_re,
  output logic signed [N:0]   o_im
);

  localparam logic [31:0] WQ32 = wq_top(P);

  logic signed [P:0]   w_wq;
  logic signed [N+P:0] w_prod_a;
  logic signed [N+P:0] w_prod_b;
  logic signed [N:0]   w_a;
  logic signed [N:0]   w_b;
  logic signed [N:0]   w_pa;
  logic signed [N:0]   w_pb;

  assign w_wq = $signed({1'b0, WQ32[P-1:0]});
  assign w_a  = (N+1)'(i_re);
  assign w_b  = (N+1)'(i_im);

  // Each component is scaled on its own and the signs applied afterwards,
  // so a conjugate pair of odd twiddles cancels exactly.
  assign w_prod_a = (N+P+1)'(i_re) * (N+P+1)'(w_wq);
  assign w_prod_b = (N+P+1)'(i_im) * (N+P+1)'(w_wq);
  assign w_pa     = (N+1)'(w_prod_a >>> P);
  assign w_pb     = (N+1)'(w_prod_b >>> P);

  always_comb begin
    o_re = w_a;
    o_im = w_b;
    case (i_idx)
      3'd0: begin o_re = w_a;         o_im = w_b;         end
      3'd1: begin o_re = w_pa - w_pb; o_im = w_pa + w_pb; end
      3'd2: begin o_re = -w_b;        o_im = w_a;         end
      3'd3: begin o_re = -w_pa - w_pb; o_im = w_pa - w_pb; end
      3'd4: begin o_re = -w_a;        o_im = -w_b;        end
      3'd5: begin o_re = w_pb - w_pa; o_im = -w_pa - w_pb; end
      3'd6: begin o_re = w_b;         o_im = -w_a;        end
      3'd7: begin o_re = w_pa + w_pb; o_im = w_pb - w_pa; end
      default: ;
    endcase
  end

endmodule

// File: rtl/idft_8_seq.sv
// 8-point IDFT, one complex MAC per cycle: LOAD 8 samples, then 8x (MAC 8, HOLD).
// Define IDFT_8_SCALE_EN to emit (acc >>> 3), a true 1/8-scaled IDFT.
module idft_8_seq
  import idft_8_pkg::*;
#(
  parameter int N = 32,
  parameter int P = 10
) (
  input logic         clk,
  input logic         rst_n,
  idft_8_seq_if.slave bus
);

  localparam logic [2:0] LAST = 3'(FRAME_LEN - 1);

  idft_state_e         r_state;
  logic        [2:0]   r_n;
  logic        [2:0]   r_k;
  logic signed [N+3:0] r_acc_r;
  logic signed [N+3:0] r_acc_i;
  logic                r_in_ready;
  logic                r_out_valid;
  logic signed [N-1:0] r_out_r;
  logic signed [N-1:0] r_out_i;
  logic        [2:0]   r_out_idx;

  logic signed [N-1:0] r_buf_r [FRAME_LEN];
  logic signed [N-1:0] r_buf_i [FRAME_LEN];

  logic                w_in_fire;
  logic        [2:0]   w_tw_idx;
  logic signed [N:0]   w_term_r;
  logic signed [N:0]   w_term_i;
  logic signed [N+3:0] w_acc_nxt_r;
  logic signed [N+3:0] w_acc_nxt_i;

  function automatic logic signed [N-1:0] out_conv(logic signed [N+3:0] a);
`ifdef IDFT_8_SCALE_EN
    return N'(a >>> 3);
`else
    return N'(a);
`endif
  endfunction

  // in_ready is registered and high only in LOAD, so it doubles as the state qualifier.
  assign w_in_fire = bus.in_valid && r_in_ready;
  assign w_tw_idx  = 3'(r_k * r_n);

  idft_tw_mul #(
    .N (N),
    .P (P)
  ) u_tw (
    .i_re  (r_buf_r[r_n]),
    .i_im  (r_buf_i[r_n]),
    .i_idx (w_tw_idx),
    .o_re  (w_term_r),
    .o_im  (w_term_i)
  );

  assign w_acc_nxt_r = r_acc_r + (N+4)'(w_term_r);
  assign w_acc_nxt_i = r_acc_i + (N+4)'(w_term_i);

  // Sample buffer carries no reset; a restarted frame overwrites it entirely.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_buf_r[r_n] <= bus.in_r;
      r_buf_i[r_n] <= bus.in_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_LOAD;
      r_n         <= '0;
      r_k         <= '0;
      r_acc_r     <= '0;
      r_acc_i     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_r     <= '0;
      r_out_i     <= '0;
      r_out_idx   <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_in_fire) begin
            r_n <= r_n + 3'd1;
            if (r_n == LAST) begin
              r_state    <= ST_MAC;
              r_in_ready <= 1'b0;
              r_k        <= '0;
              r_acc_r    <= '0;
              r_acc_i    <= '0;
            end
          end
        end
        ST_MAC: begin
          r_acc_r <= w_acc_nxt_r;
          r_acc_i <= w_acc_nxt_i;
          r_n     <= r_n + 3'd1;
          if (r_n == LAST) begin
            r_out_r     <= out_conv(w_acc_nxt_r);
            r_out_i     <= out_conv(w_acc_nxt_i);
            r_out_idx   <= r_k;
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_n         <= '0;
            r_acc_r     <= '0;
            r_acc_i     <= '0;
            if (r_k == LAST) begin
              r_state    <= ST_LOAD;
              r_in_ready <= 1'b1;
            end else begin
              r_k     <= r_k + 3'd1;
              r_state <= ST_MAC;
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_r     = r_out_r;
  assign bus.out_i     = r_out_i;
  assign bus.out_idx   = r_out_idx;

endmodule

// File: tb/tb_idft_8_seq.sv
// Directed-vector bench for idft_8_seq: frame table, backpressure, mid-frame reset, timing.
module tb_idft_8_seq;

  localparam int N  = 32;
  localparam int P  = 10;
  localparam int NV = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  idft_8_seq_if #(.N(N)) bus ();

  idft_8_seq #(.N(N), .P(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][31:0] xr;
    logic [7:0][31:0] xi;
    logic [7:0][31:0] er;
    logic [7:0][31:0] ei;
  } vec_t;

  vec_t vecs [NV];
  int   n_chk  = 0;
  int   n_fail = 0;
  time  t_prev = 0;

  function automatic logic [7:0][31:0] pack8(int a0, int a1, int a2, int a3,
                                             int a4, int a5, int a6, int a7);
    logic [7:0][31:0] p;
    p[0] = a0; p[1] = a1; p[2] = a2; p[3] = a3;
    p[4] = a4; p[5] = a5; p[6] = a6; p[7] = a7;
    return p;
  endfunction

  // Table holds unscaled results; scaled build expects floor(v/8).
  function automatic int scl(int v);
`ifdef IDFT_8_SCALE_EN
    return v >>> 3;
`else
    return v;
`endif
  endfunction

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_frame(int vi);
    int cnt;
    for (int n = 0; n < 8; n++) begin
      bus.in_valid = 1'b1;
      bus.in_r     = vecs[vi].xr[n];
      bus.in_i     = vecs[vi].xi[n];
      cnt = 0;
      while (!bus.in_ready && cnt < 200) begin
        @(posedge clk); #1;
        cnt++;
      end
      if (cnt >= 200) check("in_ready timeout", 0, 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Receive nk outputs; hold off out_ready for 5 cycles at k == bp_k.
  task automatic recv_frame(int vi, int nk, int bp_k, bit chain);
    int cnt;
    int er, ei;
    for (int k = 0; k < nk; k++) begin
      er = scl(int'($signed(vecs[vi].er[k])));
      ei = scl(int'($signed(vecs[vi].ei[k])));
      bus.out_ready = (k != bp_k);
      cnt = 0;
      while (!bus.out_valid && cnt < 100) begin
        @(posedge clk); #1;
        cnt++;
      end
      if (cnt >= 100) check("out_valid timeout", 0, 1);
      check($sformatf("v%0d k%0d latency", vi, k), cnt, 8);
      if (k == 0) begin
        if (chain) check($sformatf("v%0d frame period", vi), int'((($time - t_prev) / 10)), 80);
        t_prev = $time;
      end
      if (k == bp_k) begin
        for (int c = 0; c < 5; c++) begin
          bus.in_valid = 1'b1;
          bus.in_r     = 32'sd12345;
          bus.in_i     = -32'sd777;
          @(posedge clk); #1;
          check($sformatf("bp c%0d out_valid", c), int'(bus.out_valid), 1);
          check($sformatf("bp c%0d in_ready", c), int'(bus.in_ready), 0);
          check($sformatf("bp c%0d idx", c), int'(bus.out_idx), k);
          check($sformatf("bp c%0d re", c), int'($signed(bus.out_r)), er);
          check($sformatf("bp c%0d im", c), int'($signed(bus.out_i)), ei);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
      end
      check($sformatf("v%0d k%0d idx", vi, k), int'(bus.out_idx), k);
      check($sformatf("v%0d x[%0d].re", vi, k), int'($signed(bus.out_r)), er);
      check($sformatf("v%0d x[%0d].im", vi, k), int'($signed(bus.out_i)), ei);
      @(posedge clk); #1;
      if (k == 7) check($sformatf("v%0d in_ready after x7", vi), int'(bus.in_ready), 1);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_r      = '0;
    bus.in_i      = '0;
    bus.out_ready = 1'b0;

    // impulse, DC, real bin 1, imaginary bin 1, mixed bins 0/1/4
    vecs[0].xr = pack8(100, 0, 0, 0, 0, 0, 0, 0);
    vecs[0].xi = '0;
    vecs[0].er = pack8(100, 100, 100, 100, 100, 100, 100, 100);
    vecs[0].ei = '0;
    vecs[1].xr = pack8(8, 8, 8, 8, 8, 8, 8, 8);
    vecs[1].xi = '0;
    vecs[1].er = pack8(64, 0, 0, 0, 0, 0, 0, 0);
    vecs[1].ei = '0;
    vecs[2].xr = pack8(0, 1024, 0, 0, 0, 0, 0, 0);
    vecs[2].xi = '0;
    vecs[2].er = pack8(1024, 724, 0, -724, -1024, -724, 0, 724);
    vecs[2].ei = pack8(0, 724, 1024, 724, 0, -724, -1024, -724);
    vecs[3].xr = '0;
    vecs[3].xi = pack8(0, 1000, 0, 0, 0, 0, 0, 0);
    vecs[3].er = pack8(0, -707, -1000, -707, 0, 707, 1000, 707);
    vecs[3].ei = pack8(1000, 707, 0, -707, -1000, -707, 0, 707);
    vecs[4].xr = pack8(100, 0, 0, 0, -50, 0, 0, 0);
    vecs[4].xi = pack8(0, 1000, 0, 0, 0, 0, 0, 0);
    vecs[4].er = pack8(50, -557, -950, -557, 50, 857, 1050, 857);
    vecs[4].ei = pack8(1000, 707, 0, -707, -1000, -707, 0, 707);

    #2 rst_n = 1'b0;
    #1;
    check("rst out_valid", int'(bus.out_valid), 0);
    check("rst in_ready", int'(bus.in_ready), 1);
    check("rst out_r", int'($signed(bus.out_r)), 0);
    check("rst out_i", int'($signed(bus.out_i)), 0);
    check("rst out_idx", int'(bus.out_idx), 0);
    @(posedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < NV; v++) begin
      send_frame(v);
      recv_frame(v, 8, -1, v != 0);
    end

    send_frame(2);
    recv_frame(2, 8, 3, 1'b0);

    // Reset while computing k=2 of a frame, then a clean frame must follow.
    send_frame(4);
    recv_frame(4, 2, -1, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", int'(bus.out_valid), 0);
    check("midrst out_idx", int'(bus.out_idx), 0);
    check("midrst out_r", int'($signed(bus.out_r)), 0);
    @(posedge clk); #3 rst_n = 1'b1;
    #1;
    check("midrst in_ready after release", int'(bus.in_ready), 1);
    check("midrst out_valid after release", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    send_frame(0);
    recv_frame(0, 8, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
